// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and hazard scoreboard for the RV32I register file.
// Arbitrates ALU and LSU writebacks onto one write port and stalls issue on hazards.
module regfile_wb_sched #(
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  output logic        issue_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_d,
  output logic [31:0] pending
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [OUT_W-1:0] outstanding;
  logic [STV_W-1:0] starve_cnt;
  logic             wb_lsu;

  logic        raw_hit;
  logic        waw_hit;
  logic        cap_hit;
  logic        starved;
  logic        accept;
  logic        set_en;
  logic        clr_en;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_nxt;

  assign lsu_ready = lsu_valid & ~alu_valid;

  assign raw_hit = pending[issue_rs1] | pending[issue_rs2];
  assign waw_hit = pending[issue_rd];
  assign cap_hit = issue_long & (outstanding == OUT_W'(MAX_OUT));
  assign starved = (starve_cnt >= STV_W'(STARVE_LIMIT));

  assign issue_stall = issue_valid & (raw_hit | waw_hit | cap_hit | starved);
  assign accept      = issue_valid & ~issue_stall;

  // Clear only bits still tracked, so LSU results that straddle a reset
  // leave the outstanding count alone.
  assign set_en = accept & issue_long & (issue_rd != 5'd0);
  assign clr_en = wb_we & wb_lsu & pending[wb_rd];

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[issue_rd] = 1'b1;
    if (clr_en) clr_mask[wb_rd]    = 1'b1;
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending <= pending_nxt;
      if (set_en && !clr_en && outstanding != OUT_W'(MAX_OUT))
        outstanding <= outstanding + 1'b1;
      else if (clr_en && !set_en && outstanding != '0)
        outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we  <= 1'b0;
      wb_rd  <= '0;
      wb_d   <= '0;
      wb_lsu <= 1'b0;
    end else if (alu_valid) begin
      wb_we  <= (alu_rd != 5'd0);
      wb_rd  <= alu_rd;
      wb_d   <= alu_data;
      wb_lsu <= 1'b0;
    end else if (lsu_valid) begin
      wb_we  <= (lsu_rd != 5'd0);
      wb_rd  <= lsu_rd;
      wb_d   <= lsu_data;
      wb_lsu <= 1'b1;
    end else begin
      wb_we  <= 1'b0;
      wb_lsu <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (lsu_valid && !lsu_ready) begin
      if (starve_cnt < STV_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (MAX_OUT=4, STARVE_LIMIT=8).
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_d;
  logic [31:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_sched #(.MAX_OUT(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_long  (issue_long),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_d        (wb_d),
    .pending     (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic lng, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = v;
    issue_long  = lng;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
  endtask

  initial begin
    rst_n = 1'b0;
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    #2;
    check("rst_wb_we",   {31'd0, wb_we}, 32'd0);
    check("rst_wb_rd",   {27'd0, wb_rd}, 32'd0);
    check("rst_wb_d",    wb_d,           32'd0);
    check("rst_pending", pending,        32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ALU write latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    check("alu_wb_we", {31'd0, wb_we}, 32'd1);
    check("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
    check("alu_wb_d",  wb_d,           32'hDEADBEEF);
    alu_valid = 1'b0;
    tick();
    check("alu_wb_we_drop", {31'd0, wb_we}, 32'd0);
    check("alu_wb_rd_hold", {27'd0, wb_rd}, 32'd5);

    // RAW on a pending load destination
    set_issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    #1 check("ld7_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    check("ld7_pending", pending, 32'h0000_0080);
    set_issue(1'b0, 1'b0, 5'd9, 5'd7, 5'd0);
    #1 check("novalid_stall", {31'd0, issue_stall}, 32'd0);
    issue_valid = 1'b1;
    #1 check("raw_stall", {31'd0, issue_stall}, 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h12345678;
    #1 check("raw_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("ld7_wb_we", {31'd0, wb_we}, 32'd1);
    check("ld7_wb_rd", {27'd0, wb_rd}, 32'd7);
    check("ld7_wb_d",  wb_d,           32'h12345678);
    check("ld7_pending_held", pending, 32'h0000_0080);
    check("raw_stall_held", {31'd0, issue_stall}, 32'd1);
    tick();
    check("ld7_cleared", pending, 32'd0);
    check("raw_released", {31'd0, issue_stall}, 32'd0);
    tick();
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // ALU priority over LSU
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0003;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBBBB_0004;
    #1 check("prio_lsu_ready0", {31'd0, lsu_ready}, 32'd0);
    tick();
    check("prio_wb_rd_alu", {27'd0, wb_rd}, 32'd3);
    check("prio_wb_d_alu",  wb_d,           32'hAAAA_0003);
    alu_valid = 1'b0;
    #1 check("prio_lsu_ready1", {31'd0, lsu_ready}, 32'd1);
    tick();
    check("prio_wb_rd_lsu", {27'd0, wb_rd}, 32'd4);
    check("prio_wb_d_lsu",  wb_d,           32'hBBBB_0004);
    check("prio_wb_we_lsu", {31'd0, wb_we}, 32'd1);
    lsu_valid = 1'b0;
    tick();

    // Capacity limit
    for (int i = 1; i <= 4; i++) begin
      set_issue(1'b1, 1'b1, 5'(i), 5'd0, 5'd0);
      #1 check("cap_fill_stall", {31'd0, issue_stall}, 32'd0);
      tick();
    end
    check("cap_pending4", pending, 32'h0000_001E);
    set_issue(1'b1, 1'b0, 5'd11, 5'd0, 5'd0);
    #1 check("cap_short_ok", {31'd0, issue_stall}, 32'd0);
    set_issue(1'b1, 1'b1, 5'd10, 5'd0, 5'd0);
    #1 check("cap_full_stall", {31'd0, issue_stall}, 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h0000_1111;
    tick();
    lsu_valid = 1'b0;
    check("cap_still_stall", {31'd0, issue_stall}, 32'd1);
    tick();
    check("cap_after_commit", pending, 32'h0000_001C);
    check("cap_released", {31'd0, issue_stall}, 32'd0);
    tick();
    check("cap_fifth_pending", pending, 32'h0000_041C);
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // LSU starvation
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0020;
    lsu_valid = 1'b1; lsu_rd = 5'd2;  lsu_data = 32'h0000_2222;
    set_issue(1'b1, 1'b0, 5'd21, 5'd0, 5'd0);
    #1 check("starve_start", {31'd0, issue_stall}, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("starve_7", {31'd0, issue_stall}, 32'd0);
    tick();
    check("starve_8", {31'd0, issue_stall}, 32'd1);
    check("starve_lsu_ready0", {31'd0, lsu_ready}, 32'd0);
    alu_valid = 1'b0;
    #1 check("starve_lsu_ready1", {31'd0, lsu_ready}, 32'd1);
    check("starve_stall_held", {31'd0, issue_stall}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("starve_cleared", {31'd0, issue_stall}, 32'd0);
    check("starve_wb_rd", {27'd0, wb_rd}, 32'd2);
    tick();
    check("starve_pending", pending, 32'h0000_0418);
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // x0 destination
    set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1 check("x0_long_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("x0_long_pending", pending, 32'h0000_0418);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    tick();
    alu_valid = 1'b0;
    check("x0_alu_we", {31'd0, wb_we}, 32'd0);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h5555_5555;
    #1 check("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("x0_lsu_we", {31'd0, wb_we}, 32'd0);

    // Asynchronous reset with live state
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0006;
    tick();
    alu_valid = 1'b0;
    check("pre_rst_we", {31'd0, wb_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we",      {31'd0, wb_we}, 32'd0);
    check("async_rst_pending", pending,        32'd0);
    tick();
    rst_n = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h0000_3333;
    tick();
    lsu_valid = 1'b0;
    check("stale_ld_we", {31'd0, wb_we}, 32'd1);
    check("stale_ld_rd", {27'd0, wb_rd}, 32'd3);
    tick();
    check("stale_ld_pending", pending, 32'd0);
    for (int i = 11; i <= 14; i++) begin
      set_issue(1'b1, 1'b1, 5'(i), 5'd0, 5'd0);
      #1 check("post_rst_fill", {31'd0, issue_stall}, 32'd0);
      tick();
    end
    set_issue(1'b1, 1'b1, 5'd15, 5'd0, 5'd0);
    #1 check("post_rst_full", {31'd0, issue_stall}, 32'd1);
    check("post_rst_pending", pending, 32'h0000_7800);
    set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
